// File: rtl/norm_seq_ctrl_if.sv
// Handshake and result bus for norm_seq_ctrl.
// master: operand producer / result consumer; slave: the normalizer.
interface norm_seq_ctrl_if #(
    parameter int unsigned SIZE = 10
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] val;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      square;
    logic [1:0]      div;
    logic [SIZE-1:0] valout;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, val, out_ready,
        input  in_ready, out_valid, square, div, valout, zero, busy
    );

    modport slave (
        input  in_valid, val, out_ready,
        output in_ready, out_valid, square, div, valout, zero, busy
    );
endinterface

// File: rtl/norm_seq_ctrl.sv
// norm_seq_ctrl: bit-serial leading-one normalizer.
// An accepted operand is shifted left one bit per cycle until its MSB is set;
// the remaining count is the leading-one index. All outputs are registered.
// Optional build macro NORM_ZERO_EARLY_EXIT_EN: a zero operand skips the scan
// and completes one cycle after acceptance.
module norm_seq_ctrl #(
    parameter int unsigned SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    norm_seq_ctrl_if.slave  ns
);
    localparam int unsigned CNT_W = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]      square_q, square_d;
    logic [1:0]      div_q, div_d;
    logic [SIZE-1:0] valout_q, valout_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;
    logic            zero_flag;

    // State and output registers; reset clears everything and reopens the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            square_q    <= '0;
            div_q       <= '0;
            valout_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            square_q    <= square_d;
            div_q       <= div_d;
            valout_q    <= valout_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, datapath and result capture on entry to DONE.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        square_d  = square_q;
        div_d     = div_q;
        valout_d  = valout_q;
        zero_d    = zero_q;
        zero_flag = 1'b0;

        case (state_q)
            IDLE: begin
                if (ns.in_valid && in_ready_q) begin
`ifdef NORM_ZERO_EARLY_EXIT_EN
                    if (ns.val == '0) begin
                        sh_d      = '0;
                        cnt_d     = '0;
                        zero_flag = 1'b1;
                        state_d   = DONE;
                    end else begin
                        sh_d    = ns.val;
                        cnt_d   = CNT_W'(SIZE - 1);
                        state_d = SCAN;
                    end
`else
                    sh_d    = ns.val;
                    cnt_d   = CNT_W'(SIZE - 1);
                    state_d = SCAN;
`endif
                end
            end
            SCAN: begin
                if (sh_q[SIZE-1]) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    zero_flag = 1'b1;
                    state_d   = DONE;
                end else begin
                    sh_d  = {sh_q[SIZE-2:0], 1'b0};
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (ns.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Results are latched once and then held until the next completion.
        if (state_d == DONE && state_q != DONE) begin
            square_d = 5'(cnt_d);
            div_d    = sh_d[SIZE-2:SIZE-3];
            valout_d = sh_d;
            zero_d   = zero_flag;
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == IDLE);
    end

    assign ns.in_ready  = in_ready_q;
    assign ns.out_valid = out_valid_q;
    assign ns.busy      = busy_q;
    assign ns.square    = square_q;
    assign ns.div       = div_q;
    assign ns.valout    = valout_q;
    assign ns.zero      = zero_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Scoreboard bench for norm_seq_ctrl: stimulus pushes reference results,
// an independent monitor pops and compares whenever a result appears.
module tb_norm_seq_ctrl;
    localparam int unsigned SIZE = 10;
    localparam int CLK_P = 10;

    typedef struct {
        logic [4:0]      sq;
        logic [1:0]      dv;
        logic [SIZE-1:0] vo;
        logic            z;
        int              lat;
        time             t_acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 2;   // 0 random, 1 held low, 2 held high
    exp_t sb[$];

    norm_seq_ctrl_if #(.SIZE(SIZE)) nif ();

    norm_seq_ctrl #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .ns  (nif.slave)
    );

    always #(CLK_P/2) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: leading-one index found by scanning, result by a plain shift.
    function automatic exp_t model(input logic [SIZE-1:0] v);
        exp_t e;
        int lead = -1;
        for (int i = 0; i < int'(SIZE); i++) if (v[i]) lead = i;
        if (lead < 0) begin
            e.sq = '0; e.dv = '0; e.vo = '0; e.z = 1'b1;
`ifdef NORM_ZERO_EARLY_EXIT_EN
            e.lat = 1;
`else
            e.lat = SIZE + 1;
`endif
        end else begin
            e.vo  = v << (SIZE - 1 - lead);
            e.sq  = 5'(lead);
            e.dv  = {e.vo[SIZE-2], e.vo[SIZE-3]};
            e.z   = 1'b0;
            e.lat = 2 + (SIZE - 1 - lead);
        end
        e.t_acc = 0;
        return e;
    endfunction

    // Consumer: out_ready pattern changes just after each rising edge.
    initial begin
        nif.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       nif.out_ready = 1'($urandom_range(0, 1));
                1:       nif.out_ready = 1'b0;
                default: nif.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each new result, result stability and release timing.
    initial begin
        logic            prev_ov = 1'b0;
        logic            prev_or = 1'b0;
        logic [4:0]      p_sq = '0;
        logic [1:0]      p_dv = '0;
        logic [SIZE-1:0] p_vo = '0;
        logic            p_z = 1'b0;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
                prev_or = 1'b0;
            end else begin
                if (nif.out_valid && !prev_ov) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'(nif.valout), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", 32'(($time - e.t_acc) / CLK_P), 32'(e.lat));
                        chk("square",  32'(nif.square), 32'(e.sq));
                        chk("div",     32'(nif.div),    32'(e.dv));
                        chk("valout",  32'(nif.valout), 32'(e.vo));
                        chk("zero",    32'(nif.zero),   32'(e.z));
                    end
                end
                if (nif.out_valid && prev_ov && !prev_or)
                    chk("held_outputs", 32'({nif.square, nif.div, nif.valout, nif.zero}),
                        32'({p_sq, p_dv, p_vo, p_z}));
                if (nif.out_valid)
                    chk("in_ready_while_done", 32'({nif.in_ready, nif.busy}), 32'b01);
                if (prev_ov && prev_or)
                    chk("idle_after_handshake", 32'({nif.out_valid, nif.in_ready}), 32'b01);
                prev_ov = nif.out_valid;
                prev_or = nif.out_ready;
                p_sq = nif.square; p_dv = nif.div; p_vo = nif.valout; p_z = nif.zero;
            end
        end
    end

    // Offer one operand until accepted; the expected result is queued at acceptance.
    task automatic send(input logic [SIZE-1:0] v);
        exp_t e;
        bit   done = 0;
        @(posedge clk); #1;
        nif.in_valid = 1'b1;
        nif.val      = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (nif.in_ready) begin
                e = model(v);
                e.t_acc = $time;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        nif.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        bit idle = 0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            idle = (sb.size() == 0) && !nif.out_valid;
        end
        chk("drain", 32'(idle), 32'(1));
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 32'({nif.out_valid, nif.busy, nif.square, nif.div, nif.valout, nif.zero, nif.in_ready}),
            32'(1));
    endtask

    initial begin
        bit seen;
        nif.in_valid = 1'b0;
        nif.val      = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("ready_after_reset");

        // Directed operands with an always-ready consumer.
        ready_mode = 2;
        send(10'h200);
        send(10'h02D);
        send(10'h001);
        send(10'h000);
        send(10'h3FF);
        drain();

        // Back-pressure: pending result, a rival operand offered and refused.
        ready_mode = 1;
        send(10'h02D);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = nif.out_valid;
        end
        chk("result_pending", 32'(seen), 32'(1));
        @(posedge clk); #1;
        nif.in_valid = 1'b1;
        nif.val      = 10'h155;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("refuse_while_done", 32'({nif.in_ready, nif.out_valid}), 32'b01);
        end
        nif.in_valid = 1'b0;
        ready_mode = 2;
        drain();

        // Reset in the third SCAN cycle of 0x004 discards the operation.
        send(10'h004);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_scan");
        send(10'h100);
        drain();

        // Randomized operands, gaps and consumer back-pressure.
        ready_mode = 0;
        for (int n = 0; n < 60; n++) begin
            logic [SIZE-1:0] v;
            case ($urandom_range(0, 3))
                0:       v = SIZE'(1) << $urandom_range(0, SIZE - 1);
                1:       v = ($urandom_range(0, 4) == 0) ? '0 : SIZE'($urandom_range(1, 7));
                default: v = SIZE'($urandom);
            endcase
            send(v);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        ready_mode = 2;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
